// File: rtl/stream_arb_if.sv
// stream_arb_if: handshake bundle between two beat requesters and the
// stream_arb block arbiter feeding stream_in.
//   slave  : arbiter side (takes requests, drives rdy and the output stream)
//   master : requester/consumer side (the mirror image)
// Signals: stall, vld0/1, tin0/1, din0/1 -> arbiter
//          rdy0/1, vout, tout, dout, owner, busy, blk_done <- arbiter
interface stream_arb_if #(
    parameter int DW = 16,
    parameter int TW = 2
);
    logic          stall;
    logic          vld0, vld1;
    logic [TW-1:0] tin0, tin1;
    logic [DW-1:0] din0, din1;
    logic          rdy0, rdy1;
    logic          vout;
    logic [TW-1:0] tout;
    logic [DW-1:0] dout;
    logic          owner;
    logic          busy;
    logic          blk_done;

    modport slave (
        input  stall, vld0, vld1, tin0, tin1, din0, din1,
        output rdy0, rdy1, vout, tout, dout, owner, busy, blk_done
    );

    modport master (
        output stall, vld0, vld1, tin0, tin1, din0, din1,
        input  rdy0, rdy1, vout, tout, dout, owner, busy, blk_done
    );
endinterface

// File: rtl/stream_arb.sv
// stream_arb: two-port block arbiter in front of the stream_in deserializer.
// Ownership is granted a whole block (BEATS beats) at a time so every word
// stream_in assembles has a single source and type. One IDLE cycle separates
// blocks; stall only holds off new grants.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active low
//   s     - stream_arb_if.slave (requests in, beat stream / status out)
// Build option: STREAM_ARB_PRIO_EN selects fixed priority (port 0 wins ties)
// instead of the default round-robin.
module stream_arb #(
    parameter int DW    = 16,
    parameter int TW    = 2,
    parameter int BEATS = 8
) (
    input  logic          clk,
    input  logic          rst,
    stream_arb_if.slave   s
);
    localparam int CW = $clog2(BEATS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lp_q, lp_d;
    logic          owner_q, owner_d;
    logic          vout_q, vout_d;
    logic          done_q, done_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [DW-1:0] dout_q, dout_d;

    logic win;
    logic acc;

    // Winner of an IDLE arbitration; only meaningful when some port requests.
`ifdef STREAM_ARB_PRIO_EN
    assign win = !s.vld0;
`else
    assign win = (s.vld0 && s.vld1) ? !lp_q : s.vld1;
`endif

    // Beat transfer from the owner this cycle.
    assign acc = (state_q == BUSY) && (owner_q ? s.vld1 : s.vld0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lp_d    = lp_q;
        owner_d = owner_q;
        vout_d  = 1'b0;
        done_d  = 1'b0;
        tout_d  = tout_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (!s.stall && (s.vld0 || s.vld1)) begin
                    owner_d = win;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (acc) begin
                    vout_d = 1'b1;
                    dout_d = owner_q ? s.din1 : s.din0;
                    // Type is captured once per block, on its first beat.
                    if (cnt_q == '0) tout_d = owner_q ? s.tin1 : s.tin0;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(BEATS - 1)) begin
                        done_d  = 1'b1;
                        lp_d    = owner_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lp_q    <= 1'b1;  // port 0 wins the first tie
            owner_q <= 1'b0;
            vout_q  <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lp_q    <= lp_d;
            owner_q <= owner_d;
            vout_q  <= vout_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
            dout_q  <= dout_d;
        end
    end

    assign s.rdy0     = (state_q == BUSY) && !owner_q;
    assign s.rdy1     = (state_q == BUSY) &&  owner_q;
    assign s.vout     = vout_q;
    assign s.tout     = tout_q;
    assign s.dout     = dout_q;
    assign s.owner    = owner_q;
    assign s.busy     = (state_q == BUSY);
    assign s.blk_done = done_q;
endmodule

// File: tb/tb_stream_arb.sv
module tb_stream_arb;
    localparam int DW = 16, TW = 2, BEATS = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stream_arb_if #(.DW(DW), .TW(TW)) bus();

    stream_arb #(.DW(DW), .TW(TW), .BEATS(BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus.slave)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        logic          o;
        logic          last;
    } beat_t;

    beat_t expq[$];
    int checks = 0;
    int passed = 0;

    // Reference model: block ownership with a beats-left count.
    bit            m_busy  = 0;
    bit            m_owner = 0;
    bit            m_lp    = 1;
    int            m_left  = 0;
    logic [TW-1:0] m_type  = '0;

    int mode = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_lp = 1; m_left = 0; m_type = '0;
        expq.delete();
    endtask

    // One clock of the model, using the inputs as they stood at the edge.
    task automatic model_step(output bit a0, output bit a1);
        beat_t b;
        a0 = 0; a1 = 0;
        if (!m_busy) begin
            if (!bus.stall && (bus.vld0 || bus.vld1)) begin
`ifdef STREAM_ARB_PRIO_EN
                m_owner = bus.vld0 ? 1'b0 : 1'b1;
`else
                m_owner = (bus.vld0 && bus.vld1) ? !m_lp : bus.vld1;
`endif
                m_busy = 1;
                m_left = BEATS;
            end
        end else if (m_owner ? bus.vld1 : bus.vld0) begin
            if (m_left == BEATS) m_type = m_owner ? bus.tin1 : bus.tin0;
            b.d    = m_owner ? bus.din1 : bus.din0;
            b.t    = m_type;
            b.o    = m_owner;
            b.last = (m_left == 1);
            expq.push_back(b);
            a0 = !m_owner;
            a1 = m_owner;
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_lp   = m_owner;
            end
        end
    endtask

    task automatic drive_next(input bit a0, input bit a1);
        case (mode)
            0: begin  // directed: port 0 counting beats, type 01
                bus.vld0 = 1'b1; bus.vld1 = 1'b0; bus.stall = 1'b0;
                bus.tin0 = 2'b01;
                if (a0) bus.din0 = bus.din0 + 16'd1;
            end
            1: begin  // continuous contention
                bus.vld0 = 1'b1; bus.vld1 = 1'b1; bus.stall = 1'b0;
                if (a0) bus.din0 = 16'($urandom);
                if (a1) bus.din1 = 16'($urandom);
                bus.tin0 = 2'($urandom); bus.tin1 = 2'($urandom);
            end
            3: begin  // idle
                bus.vld0 = 1'b0; bus.vld1 = 1'b0; bus.stall = 1'b0;
            end
            default: begin  // random gaps, stall, type changes; pending data held
                if (!(bus.vld0 && !a0)) begin
                    bus.vld0 = ($urandom_range(3) != 0);
                    bus.din0 = 16'($urandom);
                end
                if (!(bus.vld1 && !a1)) begin
                    bus.vld1 = ($urandom_range(3) != 0);
                    bus.din1 = 16'($urandom);
                end
                bus.tin0  = 2'($urandom);
                bus.tin1  = 2'($urandom);
                bus.stall = ($urandom_range(3) == 0);
            end
        endcase
    endtask

    task automatic run(input int n);
        bit a0, a1;
        repeat (n) begin
            @(posedge clk);
            model_step(a0, a1);
            #1 drive_next(a0, a1);
        end
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, ".vout"},     32'(bus.vout),     0);
        chk({tag, ".tout"},     32'(bus.tout),     0);
        chk({tag, ".dout"},     32'(bus.dout),     0);
        chk({tag, ".rdy0"},     32'(bus.rdy0),     0);
        chk({tag, ".rdy1"},     32'(bus.rdy1),     0);
        chk({tag, ".owner"},    32'(bus.owner),    0);
        chk({tag, ".busy"},     32'(bus.busy),     0);
        chk({tag, ".blk_done"}, 32'(bus.blk_done), 0);
    endtask

    // Monitor: handshake/status every cycle, beat stream against scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            chk("rdy0",  32'(bus.rdy0),  32'(m_busy && !m_owner));
            chk("rdy1",  32'(bus.rdy1),  32'(m_busy &&  m_owner));
            chk("busy",  32'(bus.busy),  32'(m_busy));
            chk("owner", 32'(bus.owner), 32'(m_owner));
            chk("vout",  32'(bus.vout),  32'(expq.size() != 0));
            if (bus.vout && expq.size() != 0) begin
                e = expq.pop_front();
                chk("dout",     32'(bus.dout),     32'(e.d));
                chk("tout",     32'(bus.tout),     32'(e.t));
                chk("beat_own", 32'(bus.owner),    32'(e.o));
                chk("blk_done", 32'(bus.blk_done), 32'(e.last));
            end else if (!bus.vout) begin
                chk("blk_done_idle", 32'(bus.blk_done), 0);
            end
        end
    end

    initial begin
        int guard;
        bus.stall = 0; bus.vld0 = 0; bus.vld1 = 0;
        bus.tin0 = '0; bus.tin1 = '0; bus.din0 = 16'd1; bus.din1 = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outs("por");
        @(posedge clk);
        #1 rst = 1'b1;

        mode = 0; run(11);   // one directed block 0x0001..0x0008, type 01
        mode = 3; run(4);
        mode = 1; run(60);   // contention
        mode = 2; run(300);  // random traffic with gaps and stall

        // Reset in the middle of a block, after its fifth beat.
        guard = 0;
        while (!(m_busy && m_left == BEATS - 5) && guard < 500) begin
            run(1);
            guard++;
        end
        chk("midblock_reached", 32'(guard < 500), 1);
        rst = 1'b0;
        #1 chk_reset_outs("midrst");
        model_reset();
        mode = 1;
        bus.vld0 = 1'b1; bus.vld1 = 1'b1; bus.stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run(30);             // tie after reset must go to port 0
        mode = 2; run(300);
        mode = 3; run(20);
        chk("scoreboard_drained", 32'(expq.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
